// File: rtl/qam_demod.sv
// ---------------------------------------------------------------------------
// qam_demod : coherent 4-QAM demodulator (correlate + slice, 128-sample symbol)
// Optional erasure flag enabled by QAM_DEMOD_ERASE_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qam_demod #(
    parameter int DATA_W = 9,
    parameter int CNT_W  = 7,
    parameter int ACC_W  = 2*DATA_W + CNT_W
`ifdef QAM_DEMOD_ERASE_EN
    ,
    parameter int ERASE_THR = 4096
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     sample_en,
    input  logic signed [DATA_W-1:0] rx_in,
    input  logic signed [DATA_W-1:0] GetSin,
    input  logic signed [DATA_W-1:0] GetCos,
    output logic        [1:0]        sym_out,
    output logic                     sym_valid,
    output logic        [CNT_W-1:0]  sample_cnt,
    output logic                     busy
`ifdef QAM_DEMOD_ERASE_EN
    ,
    output logic                     sym_erase
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0]   acc_q_q, acc_q_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic        [1:0]         sym_q, sym_d;
    logic                      valid_q, valid_d;

    logic signed [2*DATA_W-1:0] p_i, p_q;
    logic signed [ACC_W-1:0]    f_i, f_q;
    logic                       decide;

    assign p_i = rx_in * GetCos;
    assign p_q = rx_in * GetSin;
    assign f_i = acc_i_q + {{(ACC_W-2*DATA_W){p_i[2*DATA_W-1]}}, p_i};
    assign f_q = acc_q_q + {{(ACC_W-2*DATA_W){p_q[2*DATA_W-1]}}, p_q};

    // Symbol end only counts when neither stop nor start overrides it
    assign decide = (state_q == ST_ACCUM) && !stop && !start && sample_en
                    && (cnt_q == {CNT_W{1'b1}});

    always_comb begin
        state_d = state_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        valid_d = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (start) begin
            state_d = ST_ACCUM;
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (state_q == ST_ACCUM && sample_en) begin
            if (decide) begin
                // Zero integral slices as I+ / Q-
                sym_d   = {f_i[ACC_W-1], ~f_q[ACC_W-1] & (|f_q)};
                valid_d = 1'b1;
                acc_i_d = '0;
                acc_q_d = '0;
                cnt_d   = '0;
            end else begin
                acc_i_d = f_i;
                acc_q_d = f_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
            sym_q   <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
        end
    end

    assign sym_out    = sym_q;
    assign sym_valid  = valid_q;
    assign sample_cnt = cnt_q;
    assign busy       = (state_q == ST_ACCUM);

`ifdef QAM_DEMOD_ERASE_EN
    localparam logic [ACC_W-1:0] ERASE_LIM = ACC_W'(ERASE_THR);

    logic [ACC_W-1:0] mag_i, mag_q;
    logic             erase_q, erase_d;

    always_comb begin
        mag_i   = f_i[ACC_W-1] ? $unsigned(-f_i) : $unsigned(f_i);
        mag_q   = f_q[ACC_W-1] ? $unsigned(-f_q) : $unsigned(f_q);
        erase_d = erase_q;
        if (decide) begin
            erase_d = (mag_i < ERASE_LIM) | (mag_q < ERASE_LIM);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            erase_q <= 1'b0;
        end else begin
            erase_q <= erase_d;
        end
    end

    assign sym_erase = erase_q;
`endif

endmodule

`default_nettype wire
